// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode type and sizing helper for the single-clock FIFO
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int count_width(input int p);
    return p + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2^ADDR_WIDTH x DATA_WIDTH register array, sync write, async read
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // storage has no reset: stale words are unreachable once the pointers clear
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ndeep.sv
// sync_fifo_ndeep: full-depth single-clock FIFO with STD/FWFT read, levels and sticky errors
module sync_fifo_ndeep
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH         = 8,
  parameter int         BUFFER_DEPTH_POWER = 2,
  parameter fifo_mode_e READ_MODE          = FIFO_STD,
  parameter int         AFULL_LVL          = (1 << BUFFER_DEPTH_POWER) - 1,
  parameter int         AEMPTY_LVL         = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          we_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  output logic                          wrdy_o,
  input  logic                          re_i,
  output logic [DATA_WIDTH-1:0]         dout_o,
  output logic                          rrdy_o,
  output logic [BUFFER_DEPTH_POWER:0]   count_o,
  output logic                          afull_o,
  output logic                          aempty_o,
  input  logic                          clr_err_i,
  output logic                          ovf_o,
  output logic                          udf_o
);
  localparam int P  = BUFFER_DEPTH_POWER;
  localparam int CW = count_width(P);
  localparam logic [CW-1:0] AF = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE = CW'(AEMPTY_LVL);
  logic [CW-1:0] wr_ptr, rd_ptr, count;
  logic [DATA_WIDTH-1:0] head, dout_q;
  logic full, empty, wr_acc, rd_acc, ovf_set, udf_set;
  // the wrap bit distinguishes full from empty, so every slot is usable
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[P-1:0] == rd_ptr[P-1:0]) && (wr_ptr[P] != rd_ptr[P]);
  assign wr_acc  = we_i & ~full & ~flush_i;
  assign rd_acc  = re_i & ~empty & ~flush_i;
  assign ovf_set = we_i & full & ~flush_i;
  assign udf_set = re_i & empty & ~flush_i;
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(P)) u_mem (
    .clk   (clk_i),
    .we    (wr_acc),
    .waddr (wr_ptr[P-1:0]),
    .wdata (din_i),
    .raddr (rd_ptr[P-1:0]),
    .rdata (head)
  );
  // pointers and fill count; flush clears them ahead of any request
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      count <= count + CW'(wr_acc) - CW'(rd_acc);
    end
  // sticky error flags; a new error outranks a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      ovf_o <= ovf_set | (ovf_o & ~clr_err_i);
      udf_o <= udf_set | (udf_o & ~clr_err_i);
    end
  // registered read data for standard mode, held between accepted reads
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) dout_q <= '0;
    else if (rd_acc) dout_q <= head;
  assign dout_o   = (READ_MODE == FIFO_FWFT) ? (empty ? '0 : head) : dout_q;
  assign wrdy_o   = ~full;
  assign rrdy_o   = ~empty;
  assign count_o  = count;
  assign afull_o  = count >= AF;
  assign aempty_o = count <= AE;
endmodule
